// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the APB UART transmitter.
// Optional parity support is selected by the UART_TX_PARITY_EN macro in the top.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    PARITY
  } tx_state_e;

  localparam logic [1:0] REG_USR = 2'd0;
  localparam logic [1:0] REG_UTD = 2'd1;

  localparam int USR_FULL_BIT     = 0;
  localparam int USR_EMPTY_BIT    = 1;
  localparam int USR_BUSY_BIT     = 2;
  localparam int USR_OVERFLOW_BIT = 3;

  function automatic logic [31:0] usr_pack(input logic overflow, input logic busy,
                                           input logic empty, input logic full);
    logic [31:0] word;
    word                   = '0;
    word[USR_FULL_BIT]     = full;
    word[USR_EMPTY_BIT]    = empty;
    word[USR_BUSY_BIT]     = busy;
    word[USR_OVERFLOW_BIT] = overflow;
    return word;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with show-ahead output; full/empty come from an
// occupancy counter so that a full FIFO is distinguishable from an empty one.
module uart_tx_fifo
  import uart_tx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_reg[rd_ptr_reg];

  always_ff @(posedge PCLK) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  // DEPTH is a power of two, so pointer wrap is the natural binary rollover.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/apb_uart_tx_periph.sv
// APB slave UART transmitter: register file, TX FIFO and 8N1 frame FSM.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module apb_uart_tx_periph
  import uart_tx_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        tx
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic        pready_reg;
  logic [31:0] prdata_reg;
  logic        overflow_reg;

  tx_state_e   state_reg, state_next;
  logic [BW-1:0] baud_cnt_reg, baud_cnt_next;
  logic [2:0]  bit_cnt_reg, bit_cnt_next;
  logic [7:0]  shift_reg, shift_next;
  logic        tx_reg, tx_next;
`ifdef UART_TX_PARITY_EN
  logic        parity_reg, parity_next;
`endif

  logic        access_start;
  logic        xfer_done;
  logic        utd_wr;
  logic        usr_rd;
  logic [1:0]  reg_idx;
  logic [31:0] rd_mux;
  logic        busy;
  logic        baud_done;

  logic        fifo_push;
  logic        fifo_pop;
  logic [7:0]  fifo_dout;
  logic        fifo_full;
  logic        fifo_empty;

  logic        unused_bits;
  assign unused_bits = &{1'b0, PADDR[1:0], PWDATA[31:8]};

  assign PREADY = pready_reg;
  assign PRDATA = prdata_reg;
  assign tx     = tx_reg;

  assign reg_idx      = PADDR[3:2];
  assign access_start = PSEL & PENABLE & ~pready_reg;
  assign xfer_done    = PSEL & PENABLE & pready_reg;
  assign utd_wr       = xfer_done & PWRITE & (reg_idx == REG_UTD);
  assign usr_rd       = xfer_done & ~PWRITE & (reg_idx == REG_USR);
  assign fifo_push    = utd_wr & ~fifo_full;
  assign busy         = (state_reg != IDLE);
  assign baud_done    = (baud_cnt_reg == BW'(DIV - 1));

  always_comb begin
    rd_mux = '0;
    if (reg_idx == REG_USR) begin
      rd_mux = usr_pack(overflow_reg, busy, fifo_empty, fifo_full);
    end
  end

  // Read data is captured with PREADY so it stays zero outside the ready cycle.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      pready_reg   <= 1'b0;
      prdata_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      pready_reg <= access_start;
      prdata_reg <= (access_start & ~PWRITE) ? rd_mux : '0;
      if (utd_wr & fifo_full) begin
        overflow_reg <= 1'b1;
      end else if (usr_rd) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .din    (PWDATA[7:0]),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    fifo_pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next   = parity_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop      = 1'b1;
          shift_next    = fifo_dout;
          baud_cnt_next = '0;
          bit_cnt_next  = '0;
          state_next    = START;
`ifdef UART_TX_PARITY_EN
          parity_next   = ^fifo_dout;
`endif
        end
      end
      START: begin
        if (baud_done) begin
          baud_cnt_next = '0;
          state_next    = DATA;
        end else begin
          baud_cnt_next = baud_cnt_reg + BW'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_cnt_next = '0;
          shift_next    = {1'b0, shift_reg[7:1]};
          bit_cnt_next  = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + BW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_done) begin
          baud_cnt_next = '0;
          state_next    = STOP;
        end else begin
          baud_cnt_next = baud_cnt_reg + BW'(1);
        end
      end
`endif
      STOP: begin
        if (baud_done) begin
          baud_cnt_next = '0;
          state_next    = IDLE;
        end else begin
          baud_cnt_next = baud_cnt_reg + BW'(1);
        end
      end
      default: begin
        baud_cnt_next = '0;
        state_next    = IDLE;
      end
    endcase

    // The line level follows the next state so tx is a clean register output.
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = parity_next;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      tx_reg       <= tx_next;
`ifdef UART_TX_PARITY_EN
      parity_reg   <= parity_next;
`endif
    end
  end

endmodule
